decoder_nxm_seq: RTL and testbench



---
 rtl/decoder_nxm_seq_if.sv | 28 ++
 rtl/decoder_nxm_seq.sv | 114 +++++++++++
 tb/tb_decoder_nxm_seq.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/decoder_nxm_seq_if.sv
// Bus bundle for decoder_nxm_seq: request handshake plus decoded select outputs.
// master drives the request side; slave is the decoder itself.
interface decoder_nxm_seq_if #(
  parameter int unsigned IN_W    = 3,
  parameter int unsigned DWELL_W = 8
) ();
  localparam int unsigned OUT_W = 2 ** IN_W;

  logic               enable;
  logic [1:0]         mode;
  logic               in_valid;
  logic               in_ready;
  logic [IN_W-1:0]    in_sel;
  logic [DWELL_W-1:0] dwell;
  logic [OUT_W-1:0]   out;
  logic               out_valid;
  logic               busy;

  modport master (
    output enable, mode, in_valid, in_sel, dwell,
    input  in_ready, out, out_valid, busy
  );

  modport slave (
    input  enable, mode, in_valid, in_sel, dwell,
    output in_ready, out, out_valid, busy
  );
endinterface

// File: rtl/decoder_nxm_seq.sv
// Registered N-to-2^N one-hot (or one-cold) decoder with valid/ready input and
// hold, timed-pulse and auto-scan output modes.
module decoder_nxm_seq #(
  parameter int unsigned IN_W       = 3,
  parameter int unsigned DWELL_W    = 8,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input logic              clk,
  input logic              rst_n,
  decoder_nxm_seq_if.slave bus
);
  localparam int unsigned OUT_W = 2 ** IN_W;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StHold  = 2'd1;
  localparam logic [1:0] StPulse = 2'd2;
  localparam logic [1:0] StScan  = 2'd3;

  localparam logic [OUT_W-1:0] Inactive = {OUT_W{ACTIVE_LOW}};
  localparam logic [OUT_W-1:0] OneHot0  = OUT_W'(1);

  logic [1:0]         state_q, state_d;
  logic [IN_W-1:0]    idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [OUT_W-1:0]   out_q, out_d;
  logic               valid_q, valid_d;
  logic               in_ready;
  logic               accept;
  logic               dwell_done;

  assign in_ready   = bus.enable & ((state_q == StIdle) | (state_q == StHold));
  assign accept     = bus.in_valid & in_ready;
  assign dwell_done = (cnt_q == dwell_q);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    dwell_d = dwell_q;
    valid_d = valid_q;

    if (!bus.enable) begin
      // Abort: drop to inactive outputs; nothing resumes when enable returns.
      state_d = StIdle;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle, StHold: begin
          if (accept) begin
            idx_d   = bus.in_sel;
            dwell_d = bus.dwell;
            cnt_d   = '0;
            valid_d = 1'b1;
            case (bus.mode)
              2'b01:   state_d = StPulse;
              2'b10:   state_d = StScan;
              default: state_d = StHold;
            endcase
          end
        end
        StPulse: begin
          if (dwell_done) begin
            state_d = StIdle;
            cnt_d   = '0;
            valid_d = 1'b0;
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
        StScan: begin
          if (dwell_done) begin
            idx_d = idx_q + IN_W'(1);  // natural wrap: OUT_W is a power of two
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + DWELL_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          valid_d = 1'b0;
        end
      endcase
    end

    // Decode from next-state values so out and out_valid always agree.
    out_d = valid_d ? ((OneHot0 << idx_d) ^ Inactive) : Inactive;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      dwell_q <= '0;
      out_q   <= Inactive;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      dwell_q <= dwell_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out       = out_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = (state_q == StPulse) | (state_q == StScan);
endmodule

// File: tb/tb_decoder_nxm_seq.sv
// Directed bench for decoder_nxm_seq: a per-cycle behavioural model checks the 8-output
// instance; a 16-output one-cold instance gets literal checks only.
module tb_decoder_nxm_seq;
  logic clk;
  logic rst_n;

  int checks;
  int errors;

  decoder_nxm_seq_if #(.IN_W(3), .DWELL_W(8)) ifa ();
  decoder_nxm_seq_if #(.IN_W(4), .DWELL_W(8)) ifb ();

  decoder_nxm_seq #(.IN_W(3), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa)
  );

  decoder_nxm_seq #(.IN_W(4), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: kind 0 idle, 1 hold, 2 pulse, 3 scan; m_left counts cycles remaining on
  // the current index after this one.
  int m_kind, m_idx, m_left, m_dwell;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_kind  <= 0;
      m_idx   <= 0;
      m_left  <= 0;
      m_dwell <= 0;
    end else if (!ifa.enable) begin
      m_kind <= 0;
    end else if (m_kind <= 1) begin
      if (ifa.in_valid) begin
        m_kind  <= (ifa.mode == 2'b01) ? 2 : (ifa.mode == 2'b10) ? 3 : 1;
        m_idx   <= int'(ifa.in_sel);
        m_left  <= int'(ifa.dwell);
        m_dwell <= int'(ifa.dwell);
      end
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
    end else if (m_kind == 2) begin
      m_kind <= 0;
    end else begin
      m_idx  <= (m_idx + 1) % 8;
      m_left <= m_dwell;
    end
  end

  function automatic logic [31:0] model_out(input int kind, input int idx);
    if (kind == 0) return 32'h0;
    return 32'h1 << idx;
  endfunction

  always @(negedge clk) begin
    check("cmp_out", {24'h0, ifa.out}, model_out(m_kind, m_idx));
    check("cmp_out_valid", {31'h0, ifa.out_valid}, {31'h0, m_kind != 0});
    check("cmp_busy", {31'h0, ifa.busy}, {31'h0, m_kind >= 2});
    check("cmp_in_ready", {31'h0, ifa.in_ready}, {31'h0, ifa.enable && m_kind <= 1});
  end

  logic [7:0] scan_exp [7];

  initial begin
    checks = 0;
    errors = 0;
    scan_exp = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};
    rst_n = 1'b0;
    ifa.enable = 1'b0; ifa.mode = 2'b00; ifa.in_valid = 1'b0; ifa.in_sel = '0; ifa.dwell = '0;
    ifb.enable = 1'b0; ifb.mode = 2'b00; ifb.in_valid = 1'b0; ifb.in_sel = '0; ifb.dwell = '0;
    step();
    step();
    rst_n = 1'b1;
    check("reset_out", {24'h0, ifa.out}, 32'h00);
    check("reset_b_out", {16'h0, ifb.out}, 32'hFFFF);
    check("reset_ready_dis", {31'h0, ifa.in_ready}, 32'h0);
    ifa.enable = 1'b1;
    #1;
    check("reset_ready_en", {31'h0, ifa.in_ready}, 32'h1);

    // HOLD, then replacement with no gap
    ifa.in_valid = 1'b1; ifa.in_sel = 3'd5; ifa.mode = 2'b00;
    step();
    ifa.in_valid = 1'b0;
    check("hold_first", {24'h0, ifa.out}, 32'h20);
    repeat (19) step();
    check("hold_20", {24'h0, ifa.out}, 32'h20);
    ifa.in_valid = 1'b1; ifa.in_sel = 3'd0;
    step();
    ifa.in_valid = 1'b0;
    check("hold_replace", {24'h0, ifa.out}, 32'h01);

    // PULSE dwell=2 with in_valid held during the pulse
    ifa.in_valid = 1'b1; ifa.in_sel = 3'd3; ifa.mode = 2'b01; ifa.dwell = 8'd2;
    step();
    check("pulse_c1", {24'h0, ifa.out}, 32'h08);
    ifa.in_sel = 3'd7; ifa.mode = 2'b00;
    check("pulse_ready0", {31'h0, ifa.in_ready}, 32'h0);
    step();
    check("pulse_c2", {24'h0, ifa.out}, 32'h08);
    step();
    check("pulse_c3", {24'h0, ifa.out}, 32'h08);
    ifa.in_valid = 1'b0;
    step();
    check("pulse_end", {24'h0, ifa.out}, 32'h00);
    check("pulse_end_busy", {31'h0, ifa.busy}, 32'h0);

    // PULSE dwell=0
    ifa.in_valid = 1'b1; ifa.in_sel = 3'd1; ifa.mode = 2'b01; ifa.dwell = 8'd0;
    step();
    ifa.in_valid = 1'b0;
    check("pulse0_on", {24'h0, ifa.out}, 32'h02);
    step();
    check("pulse0_off", {24'h0, ifa.out}, 32'h00);

    // SCAN with wrap, then enable drop
    ifa.in_valid = 1'b1; ifa.in_sel = 3'd6; ifa.mode = 2'b10; ifa.dwell = 8'd1;
    step();
    ifa.in_valid = 1'b0;
    ifa.dwell = 8'd9;
    check("scan_0", {24'h0, ifa.out}, {24'h0, scan_exp[0]});
    for (int i = 1; i < 7; i++) begin
      step();
      check("scan_seq", {24'h0, ifa.out}, {24'h0, scan_exp[i]});
    end
    ifa.enable = 1'b0;
    step();
    check("scan_abort_out", {24'h0, ifa.out}, 32'h00);
    check("scan_abort_busy", {31'h0, ifa.busy}, 32'h0);
    ifa.enable = 1'b1;
    step();
    check("no_resume", {24'h0, ifa.out}, 32'h00);

    // in_valid while disabled is ignored
    ifa.enable = 1'b0;
    ifa.in_valid = 1'b1; ifa.in_sel = 3'd2; ifa.mode = 2'b00;
    step();
    step();
    check("dis_ignore", {24'h0, ifa.out}, 32'h00);
    ifa.in_valid = 1'b0;
    ifa.enable = 1'b1;

    // Reset asserted mid-scan
    ifa.in_valid = 1'b1; ifa.in_sel = 3'd0; ifa.mode = 2'b10; ifa.dwell = 8'd3;
    step();
    ifa.in_valid = 1'b0;
    step();
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out", {24'h0, ifa.out}, 32'h00);
    check("rst_mid_valid", {31'h0, ifa.out_valid}, 32'h0);
    check("rst_mid_busy", {31'h0, ifa.busy}, 32'h0);
    step();
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", {31'h0, ifa.in_ready}, 32'h1);
    repeat (3) step();
    check("rst_no_partial", {24'h0, ifa.out}, 32'h00);

    // One-cold 16-output instance
    ifb.enable = 1'b1;
    ifb.in_valid = 1'b1; ifb.in_sel = 4'd15; ifb.mode = 2'b00;
    step();
    ifb.in_valid = 1'b0;
    check("al_hold", {16'h0, ifb.out}, 32'h7FFF);
    check("al_valid", {31'h0, ifb.out_valid}, 32'h1);
    ifb.enable = 1'b0;
    step();
    check("al_disable", {16'h0, ifb.out}, 32'hFFFF);
    check("al_valid_off", {31'h0, ifb.out_valid}, 32'h0);

    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
